// File: rtl/tx_ctrl_pkg.sv
// Shared types and constants for the Tx slice bring-up sequencer.
package tx_ctrl_pkg;

  localparam int CODE_W       = 6;
  localparam int MAX_CODE_DEF = 40;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOLD_RST,
    ST_PRBS_SEED,
    ST_RAMP,
    ST_RUN,
    ST_RAMP_DOWN
  } tx_state_e;

  // Limits a requested drive code to the decoder's legal range.
  function automatic logic [CODE_W-1:0] clamp_code(input logic [CODE_W-1:0] v,
                                                   input logic [CODE_W-1:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/ctl_code_ramp.sv
// One output-buffer drive code; moves a single step toward tgt per step strobe.
module ctl_code_ramp
  import tx_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              step,
  input  logic [CODE_W-1:0] tgt,
  output logic [CODE_W-1:0] code,
  output logic              at_tgt
);

  logic [CODE_W-1:0] code_q;
  logic [CODE_W-1:0] code_d;

  always_comb begin
    code_d = code_q;
    if (step) begin
      if (code_q < tgt) begin
        code_d = code_q + 1'b1;
      end else if (code_q > tgt) begin
        code_d = code_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      code_q <= '0;
    end else begin
      code_q <= code_d;
    end
  end

  assign code   = code_q;
  assign at_tgt = (code_q == tgt);

endmodule

// File: rtl/tx_bringup_seq.sv
// Tx slice bring-up: staged reset release, stepped drive-code ramp, orderly shutdown.
// Handshake: start/stop/inj_req are levels sampled every clk; all outputs are registered.
module tx_bringup_seq
  import tx_ctrl_pkg::*;
#(
  parameter int RST_CYCLES  = 16,
  parameter int PRBS_CYCLES = 64,
  parameter int RAMP_DIV    = 8,
  parameter int MAX_CODE    = MAX_CODE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [CODE_W-1:0] target_n,
  input  logic [CODE_W-1:0] target_p,
  input  logic              inj_req,
  output logic              rst_tx,
  output logic              rst_prbs,
  output logic [CODE_W-1:0] ctl_buf_n,
  output logic [CODE_W-1:0] ctl_buf_p,
  output logic              inj_error,
  output logic              busy,
  output logic              done
);

  localparam logic [15:0] RST_LAST  = 16'(RST_CYCLES - 1);
  localparam logic [15:0] PRBS_LAST = 16'(PRBS_CYCLES - 1);
  localparam logic [15:0] DIV_LAST  = 16'(RAMP_DIV - 1);

  tx_state_e         state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              inj_prev_q;
  logic [CODE_W-1:0] tgt_n, tgt_p, ramp_tgt_n, ramp_tgt_p;
  logic              at_n, at_p, codes_zero, step;

  assign tgt_n      = clamp_code(target_n, CODE_W'(MAX_CODE));
  assign tgt_p      = clamp_code(target_p, CODE_W'(MAX_CODE));
  assign ramp_tgt_n = (state_q == ST_RAMP_DOWN) ? '0 : tgt_n;
  assign ramp_tgt_p = (state_q == ST_RAMP_DOWN) ? '0 : tgt_p;
  assign codes_zero = (ctl_buf_n == '0) && (ctl_buf_p == '0);

  // A stop seen in RAMP must not take one last step toward the old target.
  assign step = (cnt_q == DIV_LAST) &&
                (((state_q == ST_RAMP) && !stop) || (state_q == ST_RAMP_DOWN));

  ctl_code_ramp u_ramp_n (
    .clk    (clk),
    .rst    (rst),
    .step   (step),
    .tgt    (ramp_tgt_n),
    .code   (ctl_buf_n),
    .at_tgt (at_n)
  );

  ctl_code_ramp u_ramp_p (
    .clk    (clk),
    .rst    (rst),
    .step   (step),
    .tgt    (ramp_tgt_p),
    .code   (ctl_buf_p),
    .at_tgt (at_p)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (start && !stop) state_d = ST_HOLD_RST;
      end
      ST_HOLD_RST, ST_PRBS_SEED: begin
        if (stop) begin
          state_d = codes_zero ? ST_IDLE : ST_RAMP_DOWN;
          cnt_d   = '0;
        end else if ((state_q == ST_HOLD_RST) && (cnt_q == RST_LAST)) begin
          state_d = ST_PRBS_SEED;
          cnt_d   = '0;
        end else if ((state_q == ST_PRBS_SEED) && (cnt_q == PRBS_LAST)) begin
          state_d = ST_RAMP;
          cnt_d   = '0;
        end
      end
      ST_RAMP: begin
        if (stop) begin
          state_d = codes_zero ? ST_IDLE : ST_RAMP_DOWN;
          cnt_d   = '0;
        end else if (at_n && at_p) begin
          state_d = ST_RUN;
        end else if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
        end
      end
      ST_RUN: begin
        cnt_d = '0;
        if (stop) begin
          state_d = codes_zero ? ST_IDLE : ST_RAMP_DOWN;
        end else if (!(at_n && at_p)) begin
          state_d = ST_RAMP;
        end
      end
      ST_RAMP_DOWN: begin
        if (codes_zero) begin
          state_d = ST_IDLE;
        end else if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      inj_prev_q <= 1'b0;
      rst_tx     <= 1'b1;
      rst_prbs   <= 1'b1;
      inj_error  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      inj_prev_q <= inj_req;
      rst_tx     <= (state_d == ST_IDLE) || (state_d == ST_HOLD_RST);
      rst_prbs   <= (state_d == ST_IDLE) || (state_d == ST_HOLD_RST) ||
                    (state_d == ST_PRBS_SEED);
      inj_error  <= (state_q == ST_RUN) && inj_req && !inj_prev_q;
      busy       <= (state_d != ST_IDLE) && (state_d != ST_RUN);
      done       <= (state_d == ST_RUN);
    end
  end

endmodule
